btn_frame_rx: RTL

Parametrised successor to the ad-hoc button-state capture in the SPI top level. It consumes the spi_dev_proto write stream (pw_wdata/pw_wcmd/pw_wstb/pw_end) and matches a configurable command byte. Frames are length-checked before the button vector is committed. Each press/release is converted into an ordered event stream buffered in a small FIFO, so downstream logic sees edges rather than polling levels.

---
 rtl/btn_frame_rx_pkg.sv | 24 ++
 rtl/btn_evt_fifo.sv | 52 +++++
 rtl/btn_frame_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/btn_frame_rx_pkg.sv
// Shared constants for the button-state frame receiver: command byte, button indices
// and the event FIFO entry width helper.
package btn_frame_rx_pkg;

    localparam logic [7:0] CMD_BTN_STATE = 8'hF4;

    localparam int BTN_JOY_DOWN  = 0;
    localparam int BTN_JOY_UP    = 1;
    localparam int BTN_JOY_LEFT  = 2;
    localparam int BTN_JOY_RIGHT = 3;
    localparam int BTN_JOY_PUSH  = 4;
    localparam int BTN_A         = 5;
    localparam int BTN_B         = 6;
    localparam int BTN_X         = 7;
    localparam int BTN_Y         = 8;
    localparam int BTN_START     = 9;
    localparam int BTN_BACK      = 10;

    // Event entry layout is {timestamp (optional, 16b), index, press}.
    function automatic int evt_width(input int idxw, input bit ts_en);
        return idxw + 1 + (ts_en ? 16 : 0);
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Purpose: show-ahead event FIFO, pointers one bit wider than the address.
// Latency: a push is visible at pop_vld/pop_dat the cycle after it is written.
// Backpressure: push is ignored while full; full comes only from registered pointers.
module btn_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic [PW-1:0] cnt
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign cnt     = wr_ptr - rd_ptr;
    assign full    = (cnt == PW'(DEPTH));
    assign pop_vld = (cnt != '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && pop_rdy;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign pop_dat = pop_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/btn_frame_rx.sv
// Purpose: capture CMD button frames from the SPI write stream, emit press/release events (BTNRX_TIMESTAMP_EN adds evt_time).
// Latency: pw_end -> btn_state 1 cycle; btn_state -> evt_valid 2 cycles (scan stage + FIFO write).
// Backpressure: evt_ready low stalls the scanner once the FIFO fills; changes coalesce, nothing is dropped.
module btn_frame_rx
    import btn_frame_rx_pkg::*;
#(
    parameter logic [7:0] CMD        = CMD_BTN_STATE,
    parameter int          NBYTES     = 4,
    parameter int          NBTN       = 11,
    parameter int          BTN_LSB    = 16,
    parameter int          FIFO_DEPTH = 8,
    localparam int         IDXW       = (NBTN > 1) ? $clog2(NBTN) : 1
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [7:0]      pw_wdata,
    input  logic            pw_wcmd,
    input  logic            pw_wstb,
    input  logic            pw_end,
    output logic [NBTN-1:0] btn_state,
    output logic            btn_valid,
    output logic            frame_err,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDXW-1:0] evt_idx,
`ifdef BTNRX_TIMESTAMP_EN
    output logic [15:0]     evt_time,
`endif
    output logic            evt_press
);

    localparam int SHW     = 8 * NBYTES;
    localparam int CW      = $clog2(NBYTES + 2);
    localparam int PW      = $clog2(FIFO_DEPTH) + 1;
`ifdef BTNRX_TIMESTAMP_EN
    localparam bit TS_EN   = 1'b1;
`else
    localparam bit TS_EN   = 1'b0;
`endif
    localparam int EW      = evt_width(IDXW, TS_EN);

    logic            matched, matched_nx;
    logic [CW-1:0]   byte_cnt, byte_cnt_nx;
    logic [SHW-1:0]  shift, shift_nx;
    logic            commit_ok, commit_bad;

    // The byte in the same cycle as pw_end is folded in before the commit decision.
    always_comb begin
        matched_nx  = matched;
        byte_cnt_nx = byte_cnt;
        shift_nx    = shift;
        if (pw_wstb && pw_wcmd) begin
            matched_nx  = (pw_wdata == CMD);
            byte_cnt_nx = '0;
            shift_nx    = '0;
        end else if (pw_wstb) begin
            shift_nx = SHW'({pw_wdata, shift} >> 8);
            if (byte_cnt != CW'(NBYTES + 1))
                byte_cnt_nx = byte_cnt + 1'b1;
        end
    end

    assign commit_ok  = pw_end && matched_nx && (byte_cnt_nx == CW'(NBYTES));
    assign commit_bad = pw_end && matched_nx && (byte_cnt_nx != CW'(NBYTES));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            matched   <= 1'b0;
            byte_cnt  <= '0;
            shift     <= '0;
            btn_state <= '0;
            btn_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            matched   <= pw_end ? 1'b0 : matched_nx;
            byte_cnt  <= pw_end ? '0 : byte_cnt_nx;
            shift     <= shift_nx;
            frame_err <= commit_bad;
            if (commit_ok) begin
                btn_state <= shift_nx[BTN_LSB +: NBTN];
                btn_valid <= 1'b1;
            end
        end
    end

    logic [NBTN-1:0] reported, diff, scan_mask;
    logic [IDXW-1:0] scan_idx;
    logic            scan_press, scan_go, space;
    logic            push_q;
    logic [EW-1:0]   push_dat_q, scan_dat;
    logic            fifo_full;
    logic [PW-1:0]   fifo_cnt;
    logic [EW-1:0]   fifo_dat;

    assign diff       = btn_state ^ reported;
    assign scan_mask  = diff & (~diff + NBTN'(1));
    assign scan_press = |(btn_state & scan_mask);

    always_comb begin
        scan_idx = '0;
        for (int i = 0; i < NBTN; i++)
            if (scan_mask[i])
                scan_idx = IDXW'(i);
    end

    // The staged push counts as occupied so the scan never overruns the FIFO.
    assign space   = ({1'b0, fifo_cnt} + {{PW{1'b0}}, push_q}) < (PW+1)'(FIFO_DEPTH);
    assign scan_go = (diff != '0) && !fifo_full && space;

`ifdef BTNRX_TIMESTAMP_EN
    logic [15:0] cyc_cnt, ts_latch;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cyc_cnt  <= '0;
            ts_latch <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (commit_ok)
                ts_latch <= cyc_cnt;
        end
    end

    assign scan_dat = {ts_latch, scan_idx, scan_press};
    assign evt_time = fifo_dat[EW-1 -: 16];
`else
    assign scan_dat = {scan_idx, scan_press};
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            reported   <= '0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
        end else begin
            push_q <= scan_go;
            if (scan_go) begin
                reported   <= reported ^ scan_mask;
                push_dat_q <= scan_dat;
            end
        end
    end

    btn_evt_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetq   (resetq),
        .push_vld (push_q),
        .push_dat (push_dat_q),
        .pop_vld  (evt_valid),
        .pop_rdy  (evt_ready),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .cnt      (fifo_cnt)
    );

    assign evt_idx   = fifo_dat[IDXW:1];
    assign evt_press = fifo_dat[0];

endmodule
